// File: rtl/regop_pkg.sv
// Shared types for the register-op sequencer: opcodes, source selects, instruction word, FSM states.
package regop_pkg;

  localparam int INSTR_W = 7;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    SRC_R0 = 3'd0,
    SRC_R1 = 3'd1,
    SRC_R2 = 3'd2,
    SRC_R3 = 3'd3,
    SRC_A0 = 3'd4,
    SRC_A1 = 3'd5,
    SRC_B0 = 3'd6,
    SRC_B1 = 3'd7
  } src_e;

  typedef struct packed {
    op_e        op;
    logic [1:0] dst;
    src_e       src;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/regop_sequencer_if.sv
// Program-load, operand and result handshake bundle for regop_sequencer.
interface regop_sequencer_if #(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [6:0]    prog_data;
  logic [AW:0]   prog_len;
  logic          prog_err;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a1, a0, b1, b0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y3, y2, y1, y0;
  logic          busy;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, in_valid, a1, a0, b1, b0, out_ready,
    input  prog_err, in_ready, out_valid, y3, y2, y1, y0, busy
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, in_valid, a1, a0, b1, b0, out_ready,
    output prog_err, in_ready, out_valid, y3, y2, y1, y0, busy
  );
endinterface

// File: rtl/regop_alu.sv
// Combinational two-operand register op; zero latency, no flow control.
module regop_alu
  import regop_pkg::*;
#(
  parameter int W = 16
) (
  input  op_e          op,
  input  logic [W-1:0] dst_val,
  input  logic [W-1:0] src_val,
  output logic [W-1:0] res
);

  always_comb begin
    res = dst_val;
    case (op)
      // Logical not: result is 1 only when the source is entirely zero.
      OP_NOT:  res = {{(W-1){1'b0}}, (src_val == '0)};
      OP_AND:  res = dst_val & src_val;
      OP_OR:   res = dst_val | src_val;
      OP_XOR:  res = dst_val ^ src_val;
      default: res = dst_val;
    endcase
  end

endmodule

// File: rtl/regop_sequencer.sv
// Runs a loaded register-op program over each accepted operand set, one instruction per cycle.
// Result valid len cycles after accept; held in DONE until out_ready, no input accepted meanwhile.
module regop_sequencer
  import regop_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  regop_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [AW:0]         len_q, len_d;
  logic [3:0][W-1:0]   r_q, r_d;
  logic [3:0][W-1:0]   opnd_q, opnd_d;
  logic                prog_err_q, prog_err_d;

  logic [INSTR_W-1:0]  mem [DEPTH];
  instr_t              instr;
  logic [2:0]          src_idx;
  logic [W-1:0]        src_val;
  logic [W-1:0]        alu_res;
  logic [AW:0]         len_in;
  logic                addr_ok;
  logic                mem_we;

  assign addr_ok = int'({1'b0, bus.prog_addr}) < DEPTH;
  assign mem_we  = bus.prog_we && addr_ok && (state_q == ST_IDLE);
  assign len_in  = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;

  assign instr   = instr_t'(mem[pc_q]);
  assign src_idx = instr.src;
  // Sources 4..7 read the latched operand copies in a0, a1, b0, b1 order.
  assign src_val = src_idx[2] ? opnd_q[src_idx[1:0]] : r_q[src_idx[1:0]];

  regop_alu #(.W(W)) u_alu (
    .op      (instr.op),
    .dst_val (r_q[instr.dst]),
    .src_val (src_val),
    .res     (alu_res)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    r_d        = r_q;
    opnd_d     = opnd_q;
    prog_err_d = prog_err_q | (bus.prog_we && addr_ok && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          opnd_d  = {bus.b1, bus.b0, bus.a1, bus.a0};
          r_d     = {bus.b1, bus.b0, bus.a1, bus.a0};
          pc_d    = '0;
          len_d   = len_in;
          state_d = (len_in == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        r_d[instr.dst] = alu_res;
        pc_d           = pc_q + AW'(1);
        if ({1'b0, pc_q} == (len_q - (AW+1)'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      len_q      <= '0;
      r_q        <= '0;
      opnd_q     <= '0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      len_q      <= len_d;
      r_q        <= r_d;
      opnd_q     <= opnd_d;
      prog_err_q <= prog_err_d;
    end
  end

  // Program store is deliberately not reset; a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.prog_err  = prog_err_q;
  assign bus.y0        = r_q[0];
  assign bus.y1        = r_q[1];
  assign bus.y2        = r_q[2];
  assign bus.y3        = r_q[3];

endmodule
